// File: rtl/irq_sequencer_pkg.sv
// Shared types and constants for the interrupt sequencer slice.
package irq_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int N_LINES    = 4;
  localparam int LINE_W     = $clog2(N_LINES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENTER = 2'd1,
    S_ISR   = 2'd2,
    S_EXIT  = 2'd3
  } state_e;

endpackage

// File: rtl/irq_sequencer_if.sv
// Bundle of interrupt-controller and core-side signals seen by the sequencer.
interface irq_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  import irq_pkg::*;

  logic              irq;
  logic [ADDR_W-1:0] isr_addr;
  logic [LINE_W-1:0] priority_select;
  logic [ADDR_W-1:0] pc_next;
  logic              stall;
  logic              mret;
  logic              ie_wr;
  logic              ie_wdata;
  logic              iack;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] epc;
  logic              in_isr;
  logic              mie;
  logic [LINE_W-1:0] active_line;
  logic [CNT_W-1:0]  irq_count;
  logic              spurious_mret;

  modport master (
    output irq, isr_addr, priority_select, pc_next, stall, mret, ie_wr, ie_wdata,
    input  iack, redirect, redirect_pc, epc, in_isr, mie, active_line, irq_count,
           spurious_mret
  );

  modport slave (
    input  irq, isr_addr, priority_select, pc_next, stall, mret, ie_wr, ie_wdata,
    output iack, redirect, redirect_pc, epc, in_isr, mie, active_line, irq_count,
           spurious_mret
  );
endinterface

// File: rtl/irq_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // next count: clear dominates, increment stops at all-ones
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = {CNT_W{1'b0}};
    end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/irq_sequencer.sv
// Takes interrupts from the interrupt controller, redirects fetch to the ISR
// and back to the saved PC on mret. Single level, no nesting.
module irq_sequencer
  import irq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic           clk,
  input  logic           rst,
  irq_sequencer_if.slave bus
);

  state_e            state_q, state_d;
  logic              accept_s;
  logic              exit_done_s;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic [ADDR_W-1:0] isr_target_q, isr_target_d;
  logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
  logic [LINE_W-1:0] active_line_q, active_line_d;
  logic              mie_q, mie_d;
  logic              saved_mie_q, saved_mie_d;
  logic              redirect_q, redirect_d;
  logic              in_isr_q, in_isr_d;
  logic              spur_q, spur_d;
  logic              iack_s;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic; accept is gated by rst so no iack escapes during reset
  always_comb begin
    state_d     = state_q;
    accept_s    = 1'b0;
    exit_done_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        accept_s = bus.irq & mie_q & ~bus.stall & ~rst;
        state_d  = accept_s ? S_ENTER : S_IDLE;
      end
      S_ENTER: state_d = bus.stall ? S_ENTER : S_ISR;
      S_ISR:   state_d = bus.mret ? S_EXIT : S_ISR;
      S_EXIT: begin
        exit_done_s = ~bus.stall;
        state_d     = bus.stall ? S_EXIT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // outputs: Mealy iack, state-decoded flags for the registered outputs
  always_comb begin
    iack_s     = accept_s;
    redirect_d = (state_d == S_ENTER) || (state_d == S_EXIT);
    in_isr_d   = (state_d == S_ISR) || (state_d == S_EXIT);
    spur_d     = bus.mret && ((state_q == S_IDLE) || (state_q == S_ENTER));
  end

  // datapath next values; during entry/ISR ie_wr targets the saved copy
  always_comb begin
    epc_d         = epc_q;
    isr_target_d  = isr_target_q;
    active_line_d = active_line_q;
    mie_d         = mie_q;
    saved_mie_d   = saved_mie_q;
    if (state_q == S_IDLE) begin
      if (accept_s) begin
        epc_d         = bus.pc_next;
        isr_target_d  = bus.isr_addr;
        active_line_d = bus.priority_select;
        saved_mie_d   = bus.ie_wr ? bus.ie_wdata : mie_q;
        mie_d         = 1'b0;
      end else if (bus.ie_wr) begin
        mie_d = bus.ie_wdata;
      end else begin
        mie_d = mie_q;
      end
    end else begin
      if (bus.ie_wr) begin
        saved_mie_d = bus.ie_wdata;
      end else begin
        saved_mie_d = saved_mie_q;
      end
      if (exit_done_s) begin
        mie_d = saved_mie_d;
      end else begin
        mie_d = mie_q;
      end
    end
    redirect_pc_d = (state_d == S_EXIT) ? epc_d : isr_target_d;
  end

  // datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      epc_q         <= {ADDR_W{1'b0}};
      isr_target_q  <= {ADDR_W{1'b0}};
      redirect_pc_q <= {ADDR_W{1'b0}};
      active_line_q <= {LINE_W{1'b0}};
      mie_q         <= 1'b0;
      saved_mie_q   <= 1'b0;
      redirect_q    <= 1'b0;
      in_isr_q      <= 1'b0;
      spur_q        <= 1'b0;
    end else begin
      epc_q         <= epc_d;
      isr_target_q  <= isr_target_d;
      redirect_pc_q <= redirect_pc_d;
      active_line_q <= active_line_d;
      mie_q         <= mie_d;
      saved_mie_q   <= saved_mie_d;
      redirect_q    <= redirect_d;
      in_isr_q      <= in_isr_d;
      spur_q        <= spur_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .clear_i (rst),
    .inc_i   (accept_s),
    .count_o (bus.irq_count)
  );

  assign bus.iack          = iack_s;
  assign bus.redirect      = redirect_q;
  assign bus.redirect_pc   = redirect_pc_q;
  assign bus.epc           = epc_q;
  assign bus.in_isr        = in_isr_q;
  assign bus.mie           = mie_q;
  assign bus.active_line   = active_line_q;
  assign bus.spurious_mret = spur_q;

endmodule
